// File: rtl/input_controller.sv
// input_controller: front end for the IN instruction.
// It synchronises the board switches and debounces the active-low Enter
// button. It stalls the core while an IN instruction waits for the operator.
// On a clean Enter press it captures the switches and pulses Input_Ready.
module input_controller #(
  parameter int SW_WIDTH        = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,        // asynchronous, active-low
  input  logic                Input,        // IN instruction in execute
  input  logic                Enter_n,      // raw push-button, 0 = pressed
  input  logic [SW_WIDTH-1:0] sw,           // raw switches
  output logic [31:0]         Input_Data,
  output logic                Input_Ready,
  output logic                Stall,
  output logic [SW_WIDTH-1:0] sw_sync
);

  // Counter must reach DEBOUNCE_CYCLES-1, so it needs at least one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers: stage 0 samples the pad, stage SYNC_STAGES-1 is the clean copy
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_pipe_q, sw_pipe_d;
  logic [SYNC_STAGES-1:0]               en_pipe_q, en_pipe_d;
  logic                                 enter_s;

  // Shift each synchroniser chain by one stage per cycle.
  always_comb begin
    sw_pipe_d = {sw_pipe_q[SYNC_STAGES-2:0], sw};
    en_pipe_d = {en_pipe_q[SYNC_STAGES-2:0], Enter_n};
  end

  // Synchroniser registers: switches reset low, button resets to released (high).
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would let one stage see another's new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_pipe_q <= '0;
      en_pipe_q <= '1;
    end else begin
      sw_pipe_q <= sw_pipe_d;
      en_pipe_q <= en_pipe_d;
    end
  end

  assign sw_sync = sw_pipe_q[SYNC_STAGES-1];
  assign enter_s = en_pipe_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debouncer: db_level_q holds the accepted Enter level (1 = released).
  // A differing synced level must persist for DEBOUNCE_CYCLES cycles to be accepted.
  // ---------------------------------------------------------------------------
  logic             db_level_q, db_level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             differ;
  logic             accept;
  logic             press_edge;

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first or full if/else); otherwise a latch is inferred.
  always_comb begin
    differ     = enter_s ^ db_level_q;
    accept     = differ && (db_cnt_q == CNT_MAX);
    db_level_d = accept ? enter_s : db_level_q;
    if (!differ || accept) begin
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CNT_W'(1);
    end
    // Released -> pressed transition of the debounced level, one cycle wide.
    press_edge = accept && !enter_s;
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // IN-instruction FSM: IDLE -> WAIT (stalling) -> DONE (captured, pulse once)
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] input_data_q, input_data_d;
  logic        input_ready_q, input_ready_d;

  // Next state, capture and pulse. Dropping Input always aborts, even when a press
  // edge lands in the same cycle. DONE is held while Input stays high, which
  // prevents a second capture for the same instruction.
  always_comb begin
    state_d       = state_q;
    input_data_d  = input_data_q;
    input_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Input) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!Input) begin
          state_d = ST_IDLE;
        end else if (press_edge) begin
          state_d       = ST_DONE;
          input_data_d  = 32'(sw_sync);
          input_ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!Input) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, captured data and ready-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      input_data_q  <= '0;
      input_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      input_data_q  <= input_data_d;
      input_ready_q <= input_ready_d;
    end
  end

  assign Input_Data  = input_data_q;
  assign Input_Ready = input_ready_q;
  // Stall follows Input combinationally and drops as soon as the capture is registered.
  assign Stall       = Input && (state_q != ST_DONE);

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_input_controller;

  localparam int SW_W = 10;

  logic            clk;
  logic            reset;
  logic            Input;
  logic            Enter_n;
  logic [SW_W-1:0] sw;
  logic [31:0]     Input_Data;
  logic            Input_Ready;
  logic            Stall;
  logic [SW_W-1:0] sw_sync;

  int test_cnt  = 0;
  int fail_cnt  = 0;
  int ready_cnt = 0;

  input_controller #(
    .SW_WIDTH       (SW_W),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Input      (Input),
    .Enter_n    (Enter_n),
    .sw         (sw),
    .Input_Data (Input_Data),
    .Input_Ready(Input_Ready),
    .Stall      (Stall),
    .sw_sync    (sw_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles, counting Input_Ready pulses seen at each falling edge.
  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (Input_Ready === 1'b1) ready_cnt++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    Input   = 1'b0;
    Enter_n = 1'b1;
    sw      = '0;

    // 1: reset then idle
    #1 reset = 1'b0;
    #1;
    check("rst_data",  Input_Data,  32'h0);
    check("rst_ready", {31'h0, Input_Ready}, 32'h0);
    check("rst_sw",    {22'h0, sw_sync}, 32'h0);
    cyc(3);
    reset = 1'b1;
    cyc(2);
    #1;
    check("idle_data",  Input_Data, 32'h0);
    check("idle_ready", {31'h0, Input_Ready}, 32'h0);
    check("idle_stall", {31'h0, Stall}, 32'h0);
    check("idle_sw",    {22'h0, sw_sync}, 32'h0);

    // sw_sync latency is exactly two cycles
    sw = 10'h155;
    cyc(1);
    check("sync_lat1", {22'h0, sw_sync}, 32'h0);
    cyc(1);
    check("sync_lat2", {22'h0, sw_sync}, 32'h155);

    // 2: basic capture
    sw = 10'h2A5;
    cyc(3);
    Input = 1'b1;
    #1 check("cap_stall_rise", {31'h0, Stall}, 32'h1);
    cyc(2);
    Enter_n = 1'b0;
    cyc(5);
    check("cap_ready_early", {31'h0, Input_Ready}, 32'h0);
    check("cap_stall_wait",  {31'h0, Stall}, 32'h1);
    cyc(1);
    check("cap_ready", {31'h0, Input_Ready}, 32'h1);
    check("cap_data",  Input_Data, 32'h0000_02A5);
    check("cap_stall_fall", {31'h0, Stall}, 32'h0);
    cyc(1);
    check("cap_ready_1cyc", {31'h0, Input_Ready}, 32'h0);
    check("cap_stall_done", {31'h0, Stall}, 32'h0);
    Input   = 1'b0;
    Enter_n = 1'b1;
    cyc(8);

    // 3: bounce, then one solid press
    sw = 10'h3FF;
    Input = 1'b1;
    cyc(3);
    ready_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      Enter_n = 1'b0;
      run_count(3);
      Enter_n = 1'b1;
      run_count(3);
    end
    check("bounce_no_pulse", ready_cnt, 32'd0);
    check("bounce_stall", {31'h0, Stall}, 32'h1);
    check("bounce_data_kept", Input_Data, 32'h0000_02A5);
    Enter_n = 1'b0;
    run_count(6);
    check("solid_ready", {31'h0, Input_Ready}, 32'h1);
    check("solid_data", Input_Data, 32'h0000_03FF);
    Enter_n = 1'b1;
    run_count(8);
    check("solid_one_pulse", ready_cnt, 32'd1);
    Input = 1'b0;
    cyc(2);

    // 4: button held before the IN instruction arrives
    Enter_n = 1'b0;
    sw = 10'h0C3;
    cyc(8);
    Input = 1'b1;
    ready_cnt = 0;
    run_count(10);
    check("held_no_pulse", ready_cnt, 32'd0);
    check("held_stall", {31'h0, Stall}, 32'h1);
    Enter_n = 1'b1;
    run_count(8);
    check("held_release_no_pulse", ready_cnt, 32'd0);
    sw = 10'h111;
    run_count(3);
    Enter_n = 1'b0;
    run_count(8);
    check("held_repress_pulse", ready_cnt, 32'd1);
    check("held_repress_data", Input_Data, 32'h0000_0111);

    // 5: Input held after capture, second press ignored
    sw = 10'h0AA;
    ready_cnt = 0;
    Enter_n = 1'b1;
    run_count(8);
    Enter_n = 1'b0;
    run_count(12);
    check("hold_no_pulse", ready_cnt, 32'd0);
    check("hold_data_kept", Input_Data, 32'h0000_0111);
    check("hold_stall", {31'h0, Stall}, 32'h0);
    Input   = 1'b0;
    Enter_n = 1'b1;
    cyc(8);

    // 6a: abort by dropping Input mid-debounce
    Input = 1'b1;
    cyc(2);
    ready_cnt = 0;
    Enter_n = 1'b0;
    run_count(3);
    Input = 1'b0;
    #1 check("abort_stall", {31'h0, Stall}, 32'h0);
    run_count(10);
    check("abort_no_pulse", ready_cnt, 32'd0);
    check("abort_data_kept", Input_Data, 32'h0000_0111);
    Enter_n = 1'b1;
    cyc(8);

    // 6b: Input drops in the very cycle the press is accepted; abort wins
    Input = 1'b1;
    cyc(2);
    ready_cnt = 0;
    Enter_n = 1'b0;
    run_count(5);
    Input = 1'b0;
    run_count(6);
    check("collide_no_pulse", ready_cnt, 32'd0);
    check("collide_data_kept", Input_Data, 32'h0000_0111);
    check("collide_stall", {31'h0, Stall}, 32'h0);
    Enter_n = 1'b1;
    cyc(8);

    // 6c: reset asserted while waiting
    sw = 10'h2F0;
    Input = 1'b1;
    cyc(3);
    ready_cnt = 0;
    Enter_n = 1'b0;
    run_count(3);
    reset = 1'b0;
    Input = 1'b0;
    #1;
    check("wrst_data", Input_Data, 32'h0);
    check("wrst_ready", {31'h0, Input_Ready}, 32'h0);
    check("wrst_sw", {22'h0, sw_sync}, 32'h0);
    check("wrst_stall", {31'h0, Stall}, 32'h0);
    run_count(2);
    reset = 1'b1;
    run_count(10);
    check("wrst_no_pulse", ready_cnt, 32'd0);
    check("wrst_data_after", Input_Data, 32'h0);
    check("wrst_sw_after", {22'h0, sw_sync}, 32'h2F0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
